// File: rtl/vc_traffic_pkg.sv
// Shared types and constants for the per-VC traffic source.
package vc_traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SEND    = 2'd2
  } vc_state_t;

  // Galois taps of x^32+x^22+x^2+x+1 for a left-shifting register (x^32 implicit)
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam int          ROT_STEP  = 4;

endpackage

// File: rtl/vc_traffic_lfsr.sv
// 32-bit Galois LFSR, advances every cycle; a zero seed is replaced by 1.
module vc_traffic_lfsr
  import vc_traffic_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2025
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] lfsr
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] lfsr_reg, lfsr_next;

  always_comb begin
    lfsr_next = {lfsr_reg[30:0], 1'b0} ^ (lfsr_reg[31] ? LFSR_POLY : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) lfsr_reg <= SEED_EFF;
    else         lfsr_reg <= lfsr_next;
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/vc_traffic_source.sv
// Per-VC packet traffic source: one IDLE/PENDING/SEND FSM per channel, single shared beat engine.
// Optional VC_TRAFFIC_STATS_EN adds saturating per-channel completed-packet counters (pkt_count).
module vc_traffic_source
  import vc_traffic_pkg::*;
#(
  parameter int          VC_NUM      = 3,
  parameter int          PRIO_NUM    = 2,
  parameter int          OUTPUT_NUM  = 8,
  parameter int          MAX_PKT_LEN = 16,
  parameter logic [31:0] SEED        = 32'hACE1_2025,
  localparam int         NVC         = VC_NUM * PRIO_NUM,
  localparam int         DW          = $clog2(OUTPUT_NUM),
  localparam int         LW          = $clog2(MAX_PKT_LEN + 1),
  localparam int         VW          = $clog2(NVC)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              fixed_mode,
  input  logic [NVC-1:0]    fixed_vcs,
  input  logic [DW-1:0]     fixed_dest,
  input  logic [LW-1:0]     fixed_len,
  input  logic [7:0]        rate_thr,
  input  logic [VW-1:0]     selected_vc,
  input  logic              cts,
  input  logic              beat_ready,
  output logic [NVC-1:0]    o_has_packet,
  output logic [NVC*DW-1:0] dest_o,
  output logic [NVC*VW-1:0] output_vc_o,
  output logic              beat_valid,
  output logic              beat_last,
  output logic [VW-1:0]     beat_vc,
  output logic              protocol_err
`ifdef VC_TRAFFIC_STATS_EN
  ,
  output logic [16*NVC-1:0] pkt_count
`endif
);

  logic [31:0]     lfsr;
  logic [NVC-1:0]  is_send, is_pending;
  logic [NVC*LW-1:0] len_all;
  logic            any_send, grant_ok, accept;
  logic [VW-1:0]   send_vc_reg;
  logic [LW-1:0]   beat_cnt_reg, len_sel, fixed_len_eff;
  logic            protocol_err_reg;

  vc_traffic_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .lfsr   (lfsr)
  );

  always_comb begin
    fixed_len_eff = fixed_len;
    if (fixed_len == '0)                      fixed_len_eff = LW'(1);
    else if (32'(fixed_len) > MAX_PKT_LEN)    fixed_len_eff = LW'(MAX_PKT_LEN);
  end

  assign any_send   = |is_send;
  // A grant is honoured only when the beat engine is free and the named channel is waiting
  assign grant_ok   = cts && !any_send && (32'(selected_vc) < NVC) && is_pending[selected_vc];
  assign accept     = any_send && beat_ready;
  assign len_sel    = len_all[int'(send_vc_reg)*LW +: LW];
  assign beat_valid = any_send;
  assign beat_last  = any_send && (beat_cnt_reg == LW'(len_sel - LW'(1)));
  assign beat_vc    = send_vc_reg;
  assign protocol_err = protocol_err_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      send_vc_reg      <= '0;
      beat_cnt_reg     <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      if (grant_ok) begin
        send_vc_reg  <= selected_vc;
        beat_cnt_reg <= '0;
      end else if (accept) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      if (cts && !grant_ok) protocol_err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NVC; gi++) begin : g_ch
    localparam int SH = (ROT_STEP * gi) % 32;

    logic [31:0]   rot;
    vc_state_t     state_reg, state_next;
    logic          start;
    logic [DW-1:0] dest_reg, dest_next;
    logic [VW-1:0] ovc_reg;
    logic [LW-1:0] len_reg, len_next;

    if (SH == 0) begin : g_rot0
      assign rot = lfsr;
    end else begin : g_rot
      assign rot = {lfsr[31-SH:0], lfsr[31:32-SH]};
    end

    assign start = enable && (fixed_mode ? fixed_vcs[gi] : (rot[7:0] < rate_thr));

    always_comb begin
      dest_next = fixed_mode ? fixed_dest : DW'(32'(rot[15:8]) % OUTPUT_NUM);
      len_next  = fixed_mode ? fixed_len_eff : LW'(32'(rot[31:16]) % MAX_PKT_LEN + 1);
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE:    if (start) state_next = PENDING;
        PENDING: if (grant_ok && selected_vc == VW'(gi)) state_next = SEND;
        SEND:    if (accept && beat_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        state_reg <= IDLE;
        dest_reg  <= '0;
        ovc_reg   <= '0;
        len_reg   <= '0;
      end else begin
        state_reg <= state_next;
        if (state_reg == IDLE && start) begin
          dest_reg <= dest_next;
          ovc_reg  <= VW'(gi);
          len_reg  <= len_next;
        end
      end
    end

    assign o_has_packet[gi]          = (state_reg != IDLE);
    assign is_send[gi]               = (state_reg == SEND);
    assign is_pending[gi]            = (state_reg == PENDING);
    assign dest_o[gi*DW +: DW]       = dest_reg;
    assign output_vc_o[gi*VW +: VW]  = ovc_reg;
    assign len_all[gi*LW +: LW]      = len_reg;

`ifdef VC_TRAFFIC_STATS_EN
    logic [15:0] pkt_cnt_reg;
    always_ff @(posedge clk) begin
      if (!resetn) pkt_cnt_reg <= '0;
      else if (state_reg == SEND && accept && beat_last && pkt_cnt_reg != 16'hFFFF)
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
    assign pkt_count[gi*16 +: 16] = pkt_cnt_reg;
`endif
  end

endmodule

// File: tb/tb_vc_traffic_source.sv
// Directed bench for vc_traffic_source: per-cycle vector table plus packet-level sequences.
module tb_vc_traffic_source;

  localparam int NVC = 6;
  localparam int DW  = 3;
  localparam int LW  = 5;
  localparam int VW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn, enable, fixed_mode, cts, beat_ready;
  logic [NVC-1:0]    fixed_vcs;
  logic [DW-1:0]     fixed_dest;
  logic [LW-1:0]     fixed_len;
  logic [7:0]        rate_thr;
  logic [VW-1:0]     selected_vc;
  logic [NVC-1:0]    o_has_packet;
  logic [NVC*DW-1:0] dest_o;
  logic [NVC*VW-1:0] output_vc_o;
  logic              beat_valid, beat_last, protocol_err;
  logic [VW-1:0]     beat_vc;
`ifdef VC_TRAFFIC_STATS_EN
  logic [16*NVC-1:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;
  int trace [2][36];

  vc_traffic_source dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .fixed_mode   (fixed_mode),
    .fixed_vcs    (fixed_vcs),
    .fixed_dest   (fixed_dest),
    .fixed_len    (fixed_len),
    .rate_thr     (rate_thr),
    .selected_vc  (selected_vc),
    .cts          (cts),
    .beat_ready   (beat_ready),
    .o_has_packet (o_has_packet),
    .dest_o       (dest_o),
    .output_vc_o  (output_vc_o),
    .beat_valid   (beat_valid),
    .beat_last    (beat_last),
    .beat_vc      (beat_vc),
    .protocol_err (protocol_err)
`ifdef VC_TRAFFIC_STATS_EN
    , .pkt_count  (pkt_count)
`endif
  );

  typedef struct {
    logic       rstn, en;
    logic [5:0] fvcs;
    logic       c;
    logic [2:0] sel;
    logic       rdy;
    logic [5:0] hp;
    logic       bv, bl;
    logic [2:0] bvc;
    logic       err;
    logic [2:0] d2;
  } vec_t;

  function automatic vec_t mk(input logic rstn, input logic en, input logic [5:0] f,
                              input logic c, input logic [2:0] s, input logic r,
                              input logic [5:0] hp, input logic bv, input logic bl,
                              input logic [2:0] bvc, input logic err, input logic [2:0] d2);
    vec_t v;
    v.rstn = rstn; v.en = en; v.fvcs = f; v.c = c; v.sel = s; v.rdy = r;
    v.hp = hp; v.bv = bv; v.bl = bl; v.bvc = bvc; v.err = err; v.d2 = d2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; cts = 1'b0; beat_ready = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // Grant channel vc with beat_ready held high and count beats up to beat_last
  task automatic serve(input int vc, output int n, output logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    n = 0;
    d = dest_o[vc*DW +: DW];
    cts = 1'b1; selected_vc = VW'(vc); beat_ready = 1'b1;
    @(posedge clk); #1;
    cts = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (beat_valid && beat_vc == VW'(vc)) begin
        n++;
        done = beat_last;
      end
      @(posedge clk); #1;
    end
    check($sformatf("serve%0d_last_seen", vc), 32'(done), 1);
    check($sformatf("serve%0d_hp_drop", vc), 32'(o_has_packet[vc]), 0);
  endtask

  task automatic len_test(input logic [LW-1:0] fl, input int exp_n);
    int n;
    logic [DW-1:0] d;
    fixed_mode = 1'b1; enable = 1'b1; fixed_vcs = 6'b000010; fixed_dest = 3'd3; fixed_len = fl;
    do_reset();
    @(posedge clk); #1;
    fixed_vcs = '0;
    check("len_hp", 32'(o_has_packet), 32'h02);
    check("len_dest1", 32'(dest_o[DW +: DW]), 3);
    check("len_ovc1", 32'(output_vc_o[VW +: VW]), 1);
    serve(1, n, d);
    $display("len_test fixed_len=%0d beats=%0d expected=%0d", fl, n, exp_n);
    check($sformatf("len%0d_beats", fl), n, exp_n);
  endtask

  task automatic run_trace(input int p);
    int n, vc, w, nxt;
    logic [DW-1:0] d;
    fixed_mode = 1'b0; enable = 1'b1; rate_thr = 8'd255;
    do_reset();
    w = 0;
    while (o_has_packet != '1 && w < 60) begin
      @(posedge clk); #1; w++;
    end
    check("rnd_all_req", 32'(o_has_packet), 32'h3F);
    nxt = 0;
    for (int k = 0; k < 12; k++) begin
      w = 0;
      while (o_has_packet == '0 && w < 60) begin
        @(posedge clk); #1; w++;
      end
      vc = -1;
      for (int j = 0; j < NVC; j++)
        if (vc < 0 && o_has_packet[(nxt + j) % NVC]) vc = (nxt + j) % NVC;
      check("rnd_req_found", 32'(vc >= 0), 1);
      if (vc >= 0) begin
        check("rnd_ovc", 32'(output_vc_o[vc*VW +: VW]), vc);
        serve(vc, n, d);
        $display("trace run=%0d pkt=%0d vc=%0d dest=%0d len=%0d", p, k, vc, d, n);
        check("rnd_len_range", 32'(n >= 1 && n <= 16), 1);
        trace[p][3*k] = vc; trace[p][3*k+1] = int'(d); trace[p][3*k+2] = n;
        nxt = (vc + 1) % NVC;
      end
    end
  endtask

  initial begin
    vec_t v [20];
    int seen, diffs;

    resetn = 1'b0; enable = 1'b0; fixed_mode = 1'b1; fixed_vcs = '0; fixed_dest = 3'd5;
    fixed_len = 5'd3; rate_thr = 8'd0; selected_vc = '0; cts = 1'b0; beat_ready = 1'b0;

    //        rstn en  fvcs       c  sel rdy  hp         bv bl bvc err d2
    v[0]  = mk(0, 1, 6'b000100, 0, 0, 1, 6'b000000, 0, 0, 0, 0, 0);
    v[1]  = mk(1, 1, 6'b000100, 0, 0, 1, 6'b000100, 0, 0, 0, 0, 5);
    v[2]  = mk(1, 1, 6'b000000, 1, 2, 1, 6'b000100, 1, 0, 2, 0, 5);
    v[3]  = mk(1, 1, 6'b000000, 0, 0, 1, 6'b000100, 1, 0, 2, 0, 5);
    v[4]  = mk(1, 1, 6'b000000, 0, 0, 1, 6'b000100, 1, 1, 2, 0, 5);
    v[5]  = mk(1, 1, 6'b000000, 0, 0, 1, 6'b000000, 0, 0, 0, 0, 5);
    v[6]  = mk(1, 1, 6'b010100, 0, 0, 0, 6'b010100, 0, 0, 0, 0, 5);
    v[7]  = mk(1, 1, 6'b000000, 1, 2, 0, 6'b010100, 1, 0, 2, 0, 5);
    v[8]  = mk(1, 1, 6'b000000, 0, 0, 1, 6'b010100, 1, 0, 2, 0, 5);
    v[9]  = mk(1, 1, 6'b000000, 1, 4, 0, 6'b010100, 1, 0, 2, 1, 5);
    v[10] = mk(1, 1, 6'b000000, 0, 0, 0, 6'b010100, 1, 0, 2, 1, 5);
    v[11] = mk(1, 1, 6'b000000, 0, 0, 1, 6'b010100, 1, 1, 2, 1, 5);
    v[12] = mk(1, 1, 6'b000000, 0, 0, 1, 6'b010000, 0, 0, 0, 1, 5);
    v[13] = mk(1, 1, 6'b000000, 1, 4, 0, 6'b010000, 1, 0, 4, 1, 5);
    v[14] = mk(0, 1, 6'b000000, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    v[15] = mk(1, 0, 6'b111110, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    v[16] = mk(1, 1, 6'b000001, 0, 0, 0, 6'b000001, 0, 0, 0, 0, 0);
    v[17] = mk(1, 1, 6'b000000, 1, 3, 0, 6'b000001, 0, 0, 0, 1, 0);
    v[18] = mk(1, 1, 6'b000000, 1, 0, 1, 6'b000001, 1, 0, 0, 1, 0);
    v[19] = mk(1, 1, 6'b000000, 0, 0, 1, 6'b000001, 1, 0, 0, 1, 0);

    for (int k = 0; k < 20; k++) begin
      resetn = v[k].rstn; enable = v[k].en; fixed_vcs = v[k].fvcs;
      cts = v[k].c; selected_vc = v[k].sel; beat_ready = v[k].rdy;
      @(posedge clk); #1;
      $display("vec %0d: hp=%b bv=%b bl=%b bvc=%0d err=%b dest2=%0d ovc2=%0d",
               k, o_has_packet, beat_valid, beat_last, beat_vc, protocol_err,
               dest_o[2*DW +: DW], output_vc_o[2*VW +: VW]);
      check($sformatf("v%0d_has_packet", k), 32'(o_has_packet), 32'(v[k].hp));
      check($sformatf("v%0d_beat_valid", k), 32'(beat_valid), 32'(v[k].bv));
      check($sformatf("v%0d_beat_last", k), 32'(beat_last), 32'(v[k].bl));
      check($sformatf("v%0d_protocol_err", k), 32'(protocol_err), 32'(v[k].err));
      check($sformatf("v%0d_dest2", k), 32'(dest_o[2*DW +: DW]), 32'(v[k].d2));
      if (v[k].bv || !v[k].rstn)
        check($sformatf("v%0d_beat_vc", k), 32'(beat_vc), 32'(v[k].bvc));
      if (k == 1 || k == 6)
        check($sformatf("v%0d_ovc2", k), 32'(output_vc_o[2*VW +: VW]), 2);
    end

    // Length handling including zero and over-range fixed_len
    len_test(5'd0, 1);
    len_test(5'd1, 1);
    len_test(5'd7, 7);
    len_test(5'd16, 16);
    len_test(5'd31, 16);

    // Random mode with rate_thr=0 must never start a packet
    fixed_mode = 1'b0; enable = 1'b1; rate_thr = 8'd0;
    do_reset();
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (o_has_packet != '0) seen++;
    end
    $display("rate_thr=0: cycles with requests=%0d", seen);
    check("thr0_no_requests", seen, 0);

    // Same seed after reset must replay the same packet sequence
    run_trace(0);
    run_trace(1);
    diffs = 0;
    for (int i = 0; i < 36; i++)
      if (trace[0][i] != trace[1][i]) diffs++;
    $display("trace replay differences=%0d", diffs);
    check("trace_reproducible", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
